// File: rtl/sample_packer_if.sv
// Sample-in / packet-word-out handshake bundle for sample_packer.
// master = sample source and packet FIFO side; slave = the packer itself.
interface sample_packer_if;
  logic        sample_valid;
  logic [2:0]  sample_data;
  logic        sample_ready;
  logic        flush;
  logic        packet_full;
  logic        packet_write;
  logic [15:0] packet_data;

  modport master (
    output sample_valid,
    output sample_data,
    output flush,
    output packet_full,
    input  sample_ready,
    input  packet_write,
    input  packet_data
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  flush,
    input  packet_full,
    output sample_ready,
    output packet_write,
    output packet_data
  );
endinterface

// File: rtl/sample_packer.sv
// Packs 3-bit samples into a continuous LSB-first bitstream of 16-bit packet words,
// with a one-word output register, zero-padded flush and drop accounting.
module sample_packer #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk_sample,
  input  logic                   reset_n,
  sample_packer_if.slave         bus,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] total_sample_count,
  output logic [COUNT_WIDTH-1:0] dropped_count
);

  logic [17:0]            acc_q, acc_d;
  logic [4:0]             acc_bits_q, acc_bits_d;
  logic                   out_valid_q, out_valid_d;
  logic [15:0]            out_data_q, out_data_d;
  logic                   flush_pending_q, flush_pending_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] dropped_q, dropped_d;

  logic slot_free;
  logic ready;
  logic accept;
  logic drop;
  logic pop;

  always_comb begin
    slot_free = !out_valid_q || !bus.packet_full;
    ready     = reset_n && slot_free && !flush_pending_q;
    accept    = bus.sample_valid && ready;
    drop      = bus.sample_valid && !ready;
    pop       = out_valid_q && !bus.packet_full;
  end

  assign bus.sample_ready    = ready;
  assign bus.packet_write    = pop;
  assign bus.packet_data     = out_data_q;
  assign overflow            = overflow_q;
  assign total_sample_count  = total_q;
  assign dropped_count       = dropped_q;

  always_comb begin
    acc_d           = acc_q;
    acc_bits_d      = acc_bits_q;
    out_valid_d     = out_valid_q && !pop;
    out_data_d      = out_data_q;
    flush_pending_d = flush_pending_q;
    overflow_d      = overflow_q;
    total_d         = total_q;
    dropped_d       = dropped_q;

    if (accept) begin
      // Bits above acc_bits are always zero, so OR-ing in the new sample is safe.
      acc_d      = acc_q | (18'(bus.sample_data) << acc_bits_q);
      acc_bits_d = acc_bits_q + 5'd3;
      total_d    = total_q + 1'b1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != {COUNT_WIDTH{1'b1}}) begin
        dropped_d = dropped_q + 1'b1;
      end
    end

    // A word can only complete on an accept, which already required a free slot.
    if (acc_bits_d >= 5'd16) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_d[15:0];
      acc_d       = acc_d >> 16;
      acc_bits_d  = acc_bits_d - 5'd16;
    end else if (flush_pending_q && (acc_bits_d != 5'd0) && slot_free) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_d[15:0];
      acc_d       = '0;
      acc_bits_d  = 5'd0;
    end

    if (flush_pending_q) begin
      if (acc_bits_q == 5'd0) begin
        flush_pending_d = 1'b0;
      end
    end else if (bus.flush) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      acc_q           <= '0;
      acc_bits_q      <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      total_q         <= '0;
      dropped_q       <= '0;
    end else begin
      acc_q           <= acc_d;
      acc_bits_q      <= acc_bits_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      total_q         <= total_d;
      dropped_q       <= dropped_d;
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed cases plus a randomised run checked by a
// bitstream-level scoreboard of expected packet words.
module tb_sample_packer;

  logic        clk_sample = 1'b0;
  logic        reset_n    = 1'b0;
  logic        overflow;
  logic [31:0] total_sample_count;
  logic [31:0] dropped_count;

  always #5 clk_sample = ~clk_sample;

  sample_packer_if bus ();

  sample_packer #(
    .COUNT_WIDTH(32)
  ) dut (
    .clk_sample         (clk_sample),
    .reset_n            (reset_n),
    .bus                (bus),
    .overflow           (overflow),
    .total_sample_count (total_sample_count),
    .dropped_count      (dropped_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_drop  = 0;
  logic        exp_bits[$];
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [2:0] d, input logic f);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    bus.flush        = f;
    cycle();
    bus.sample_valid = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [15:0] e[$]);
    check({tag, "_nwords"}, wr_log.size(), e.size());
    for (int i = 0; i < e.size() && i < wr_log.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), wr_log[i], e[i]);
    end
    wr_log.delete();
  endtask

  task automatic model_clear();
    exp_bits.delete();
    exp_q.delete();
    wr_log.delete();
    n_acc  = 0;
    n_drop = 0;
  endtask

  // Scoreboard: stream-level model of the packed bitstream, evaluated mid-cycle.
  always @(negedge clk_sample) begin
    if (reset_n) begin
      if (bus.packet_write) begin
        wr_log.push_back(bus.packet_data);
        if (exp_q.size() == 0) begin
          check("unexpected_write", bus.packet_data, 32'hFFFF_FFFF);
        end else begin
          check("sb_word", bus.packet_data, exp_q.pop_front());
        end
      end
      if (bus.sample_valid && bus.sample_ready) begin
        n_acc++;
        for (int i = 0; i < 3; i++) exp_bits.push_back(bus.sample_data[i]);
        if (exp_bits.size() >= 16) begin
          logic [15:0] w;
          for (int i = 0; i < 16; i++) w[i] = exp_bits.pop_front();
          exp_q.push_back(w);
        end
      end else if (bus.sample_valid) begin
        n_drop++;
      end
      if (bus.flush && exp_bits.size() > 0) begin
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16 && exp_bits.size() > 0; i++) w[i] = exp_bits.pop_front();
        exp_q.push_back(w);
      end
    end
  end

  initial begin
    logic [15:0] e[$];
    logic [31:0] t0;

    bus.sample_valid = 1'b0;
    bus.sample_data  = 3'b000;
    bus.flush        = 1'b0;
    bus.packet_full  = 1'b0;

    // Reset values
    #1;
    check("rst_write", bus.packet_write, 0);
    check("rst_data", bus.packet_data, 0);
    check("rst_ready", bus.sample_ready, 0);
    check("rst_overflow", overflow, 0);
    check("rst_total", total_sample_count, 0);
    check("rst_dropped", dropped_count, 0);
    idle(2);
    reset_n = 1'b1;
    cycle();
    check("ready_after_rst", bus.sample_ready, 1);

    // 16 x 101 back-to-back
    for (int i = 0; i < 16; i++) send(3'b101, 1'b0);
    idle(3);
    e = {16'hDB6D, 16'h6DB6, 16'hB6DB};
    check_log("t1", e);
    check("t1_total", total_sample_count, 16);
    check("t1_acc_bits", 32'(dut.acc_bits_q), 0);

    // Single sample then flush, then realignment on a new word
    send(3'b111, 1'b0);
    send(3'b000, 1'b0);
    bus.sample_valid = 1'b0;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    idle(4);
    send(3'b011, 1'b1);
    idle(4);
    check("t2_total", total_sample_count, 19);

    wr_log.delete();
    exp_q.delete();
    // Redo cleanly without the extra 000 sample to check the exact flushed words
    reset_n = 1'b0;
    model_clear();
    #1;
    reset_n = 1'b1;
    cycle();
    send(3'b111, 1'b0);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    idle(4);
    send(3'b011, 1'b1);
    idle(4);
    e = {16'h0007, 16'h0003};
    check_log("t2", e);

    // Flush in the cycle of the straddling 6th sample
    for (int i = 0; i < 5; i++) send(3'b101, 1'b0);
    send(3'b101, 1'b1);
    check("t3_ready_busy0", bus.sample_ready, 0);
    cycle();
    check("t3_ready_busy1", bus.sample_ready, 0);
    idle(3);
    check("t3_ready_back", bus.sample_ready, 1);
    e = {16'hDB6D, 16'h0002};
    check_log("t3", e);

    // Back-pressure: word held while packet_full, offered samples dropped
    t0 = total_sample_count;
    bus.packet_full = 1'b1;
    for (int i = 0; i < 6; i++) send(3'b101, 1'b0);
    for (int i = 0; i < 5; i++) send(3'b010, 1'b0);
    check("t4_ready_full", bus.sample_ready, 0);
    check("t4_write_full", bus.packet_write, 0);
    check("t4_data_held", bus.packet_data, 16'hDB6D);
    check("t4_dropped", dropped_count, 5);
    check("t4_overflow", overflow, 1);
    bus.packet_full = 1'b0;
    #1;
    check("t4_ready_release", bus.sample_ready, 1);
    idle(1);
    check("t4_one_write", wr_log.size(), 1);
    for (int i = 0; i < 10; i++) send(3'b101, 1'b0);
    idle(3);
    e = {16'hDB6D, 16'h6DB6, 16'hB6DB};
    check_log("t4", e);
    check("t4_total_delta", total_sample_count - t0, 16);
    check("t4_overflow_sticky", overflow, 1);

    // Reset mid-word
    for (int i = 0; i < 3; i++) send(3'b110, 1'b0);
    check("t5_acc_bits", 32'(dut.acc_bits_q), 9);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("t5_write", bus.packet_write, 0);
    check("t5_data", bus.packet_data, 0);
    check("t5_ready", bus.sample_ready, 0);
    check("t5_overflow", overflow, 0);
    check("t5_total", total_sample_count, 0);
    check("t5_dropped", dropped_count, 0);
    idle(2);
    reset_n = 1'b1;
    cycle();
    check("t5_no_write", wr_log.size(), 0);
    for (int i = 0; i < 16; i++) send(3'b101, 1'b0);
    idle(3);
    e = {16'hDB6D, 16'h6DB6, 16'hB6DB};
    check_log("t5", e);
    check("t5_total_after", total_sample_count, 16);

    // Randomised traffic, back-pressure and flushes
    for (int i = 0; i < 2000; i++) begin
      bus.sample_valid = ($urandom_range(0, 9) < 7);
      bus.sample_data  = 3'($urandom);
      bus.packet_full  = ($urandom_range(0, 9) < 3);
      bus.flush        = ($urandom_range(0, 29) == 0);
      cycle();
    end
    bus.sample_valid = 1'b0;
    bus.packet_full  = 1'b0;
    bus.flush        = 1'b0;
    idle(4);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    idle(6);
    check("rnd_exp_empty", exp_q.size(), 0);
    check("rnd_bits_empty", exp_bits.size(), 0);
    check("rnd_total", total_sample_count, n_acc);
    check("rnd_dropped", dropped_count, n_drop);
    check("rnd_overflow", overflow, (n_drop > 0) ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
